parity4_rx: RTL

- Receive end of the 4-bit even-parity link; the parity4 generator block drives the transmit end.
- Accepts a serial frame on one wire: start bit, data a/b/c/d, parity bit, stop bit.
- Checks the frame, then presents the nibble with per-frame status pulses and a saturating error counter.
- Drives one board LED that shows the result of the most recent frame.

---
 rtl/parity4_rx_if.sv | 34 +++
 rtl/parity4_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/parity4_rx_if.sv
// ---------------------------------------------------------------------------
// parity4_rx_if
// Bundles the serial line and the decoded-frame outputs of the 4-bit
// even-parity receiver.
//   rxd         serial line into the receiver (idles high)
//   data        last received nibble, bit0=a .. bit3=d
//   data_valid  one-cycle pulse per frame with a good stop bit
//   parity_err  one-cycle pulse, with data_valid, when parity fails
//   frame_err   one-cycle pulse when the stop bit samples low
//   err_cnt     saturating count of parity plus frame errors
//   led         high while the latest completed frame was in error
// Modports: master = line driver / result consumer, slave = receiver.
// ---------------------------------------------------------------------------
interface parity4_rx_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 rxd;
  logic [3:0]           data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 led;

  modport master (
    output rxd,
    input  data, data_valid, parity_err, frame_err, err_cnt, led
  );

  modport slave (
    input  rxd,
    output data, data_valid, parity_err, frame_err, err_cnt, led
  );
endinterface

// File: rtl/parity4_rx.sv
// ---------------------------------------------------------------------------
// parity4_rx
// Receive end of the 4-bit even-parity serial link. Frame, LSB first:
// start(0), a, b, c, d, p, stop(1); a^b^c^d^p must be 0.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  parity4_rx_if.slave: rxd in; data, data_valid, parity_err,
//        frame_err, err_cnt, led out (all outputs registered)
// Parameters:
//   CLK_DIV    clock cycles per serial bit (>= 4)
//   ERR_CNT_W  width of the saturating error counter
// ---------------------------------------------------------------------------
module parity4_rx #(
  parameter int CLK_DIV   = 12,
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  parity4_rx_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [1:0]           r_idx;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [3:0]           r_shift;
  logic                 r_par;
  logic [3:0]           r_data;
  logic                 r_dv;
  logic                 r_pe;
  logic                 r_fe;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_led;

  logic                 w_fall;
  logic                 w_bit_end;
  logic                 w_par_fail;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- line synchronizer and edge history ----
  // r_prev holds the previous rxd_s so a falling edge needs the line to have
  // been seen high first; this is what re-arms IDLE after a held-low line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall     = ~r_sync2 & r_prev;
  assign w_bit_end  = (r_div == DIV_LAST);
  assign w_par_fail = ^{r_shift, r_par};

  // ---- bit capture (datapath, no reset needed) ----
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && w_bit_end)
      r_shift[r_idx] <= r_sync2;
    if (r_state == S_PARITY && w_bit_end)
      r_par <= r_sync2;
  end

  // ---- frame FSM and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_err_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_fe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_div   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          // Mid-bit check of the start bit rejects short glitches.
          if (r_div == DIV_MID) begin
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_div   <= '0;
              r_idx   <= '0;
              r_state <= S_DATA;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_div <= '0;
            r_idx <= r_idx + 1'b1;
            if (r_idx == 2'd3)
              r_state <= S_PARITY;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_div   <= '0;
            r_state <= S_STOP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_div   <= '0;
            r_state <= S_IDLE;
            if (r_sync2) begin
              r_data <= r_shift;
              r_dv   <= 1'b1;
              r_pe   <= w_par_fail;
              r_led  <= w_par_fail;
              if (w_par_fail)
                r_err_cnt <= sat_inc(r_err_cnt);
            end else begin
              // Bad stop bit: data is untrusted, so keep the old nibble and
              // count only the framing error.
              r_fe      <= 1'b1;
              r_led     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_dv;
  assign bus.parity_err = r_pe;
  assign bus.frame_err  = r_fe;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.led        = r_led;

endmodule
